alu_req_sched: RTL and testbench
================================

Name: alu_req_sched

Overview:
- Round-robin scheduler that shares one 64-bit combinational ALU (ADD/SUB/AND/OR/BEQ, 4-bit control) between two requesters.
- Arbitrates, latches operands, and holds the ALU inputs stable for a configurable settle time so the 64-bit ripple-carry path can resolve.
- Captures the result and flags, then returns them over a valid/ready response channel tagged with the requester ID.
- Sits between the issue logic and the shared ALU instance; the ALU itself is external.

Parameters:
- EXEC_CYCLES, 2, cycles ALU inputs are held before capture (min 1).
- WIDTH, 64, operand/result width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req0_valid  in  1  requester 0 has an op
- req0_ready  out  1  requester 0 op accepted this cycle
- req0_a, req0_b  in  WIDTH  operands
- req0_op  in  4  ALU control code
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as req0 for requester 1
- alu_a, alu_b  out  WIDTH  to shared ALU
- alu_ctrl  out  4  to shared ALU
- alu_result  in  WIDTH  from ALU
- alu_zero, alu_carry, alu_ovf, alu_neg  in  1 each  ALU flags
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- resp_id  out  1  requester that issued the op
- resp_result  out  WIDTH  captured result
- resp_flags  out  4  {zero, carry, ovf, neg}
- resp_err  out  1  illegal op code

Behaviour:
- Reset: state IDLE; rr_ptr=0 (req0 favoured first); all outputs 0, i.e. alu_a/alu_b/alu_ctrl, resp_*, req*_ready.
- Legal codes: ADD 4'b0000, SUB 4'b0001, AND 4'b0100, OR 4'b0101, BEQ 4'b1010.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant = the single valid requester; if both are valid, the one selected by rr_ptr.
  - reqN_ready = (state==IDLE) & grantN. This is combinational; at most one ready is high per cycle.
  - On the handshake: latch a, b, op and id; rr_ptr <= ~id; load exec counter with EXEC_CYCLES-1; go to EXEC.
  - No valid requester: remain in IDLE.
- EXEC:
  - alu_a, alu_b, alu_ctrl are driven from the latched registers and stay constant for the whole state.
  - Counter decrements each cycle. When the counter is 0: capture alu_result and flags into the resp_* registers, set resp_valid, go to RESP.
- Illegal op:
  - Still takes EXEC_CYCLES cycles; alu_ctrl is driven to 4'b0000.
  - Capture resp_result=0, resp_flags=0, resp_err=1.
  - resp_err=0 for legal ops.
- RESP:
  - resp_* are held stable while resp_valid & ~resp_ready.
  - On resp_valid & resp_ready: resp_valid <= 0, go to IDLE.
  - A new grant can occur no earlier than the next cycle (no IDLE bypass). req*_ready stays 0 in EXEC and RESP.
- Latency: handshake in cycle t; resp_valid asserts in cycle t+EXEC_CYCLES+1. Throughput is 1 op per EXEC_CYCLES+2 cycles with resp_ready held at 1.
- Fairness: with both requesters continuously valid, grants strictly alternate.
- Requester dropping valid: may happen at any time before its ready; it is then simply not granted.
- Reset mid-operation (EXEC or RESP): the transaction is discarded without a response, and the block returns to reset values the next cycle.
- alu_a/alu_b/alu_ctrl keep their last values in IDLE and RESP; they are reset to 0 only by rst.

Optional Feature:
- Macro: ALU_REQ_SCHED_STATS_EN.
- Defined:
  - Adds outputs grant_cnt0 and grant_cnt1 (16 bits each), incremented on each accepted handshake of the matching requester.
  - Adds output err_cnt (16 bits), incremented on each illegal-op capture.
  - All three counters saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and the counter logic are absent; all other behaviour is identical.

Test Plan:
- Single ADD, EXEC_CYCLES=2:
  - Stimulus: req0 issues a=64'd5, b=64'd7, op=0000 in cycle t.
  - Response: req0_ready=1 in cycle t; resp_valid=1 in cycle t+3 with resp_result=12, resp_id=0, resp_flags=0, resp_err=0.
- Contention:
  - Stimulus: both requesters valid continuously, req0 SUB(3,3), req1 OR(8'hF0, 8'h0F).
  - Response: grant order is 0,1,0,1; req0 responses have result 0 with zero=1; req1 responses have result 64'hFF.
- Backpressure:
  - Stimulus: resp_ready=0 for 5 cycles after resp_valid rises.
  - Response: resp_result and resp_id stay stable; no req*_ready pulses; completion occurs on the cycle resp_ready rises.
- Illegal op:
  - Stimulus: req1 issues op=4'b0111.
  - Response: resp_err=1, resp_result=0, resp_flags=0 at latency EXEC_CYCLES+1; the next op is handled normally.
- Reset mid-EXEC:
  - Stimulus: assert rst one cycle after a grant.
  - Response: no resp_valid; rr_ptr=0. With both requesters then valid, req0 is granted first.
- Stats (macro defined):
  - Stimulus: 3 req0 ops, 2 req1 ops, 1 illegal op.
  - Response: grant_cnt0 and grant_cnt1 match the accepted handshake counts per requester; err_cnt=1.

Source files
------------

// File: rtl/alu_req_sched_if.sv
// alu_req_sched_if
//   Bundles the request, shared-ALU and response signals of alu_req_sched.
//   Parameter: WIDTH - operand/result width.
//   Modports:
//     slave  - the scheduler side. It receives reqN_*, drives reqN_ready,
//              drives alu_a/alu_b/alu_ctrl, receives alu_result and the ALU
//              flags, drives resp_*, and receives resp_ready.
//     master - the surrounding side: the requesters, the ALU and the response
//              consumer.
interface alu_req_sched_if #(
  parameter int unsigned WIDTH = 64
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [3:0]       req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [3:0]       req1_op;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             alu_carry;
  logic             alu_ovf;
  logic             alu_neg;

  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [WIDTH-1:0] resp_result;
  logic [3:0]       resp_flags;
  logic             resp_err;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output alu_a, alu_b, alu_ctrl,
    input  alu_result, alu_zero, alu_carry, alu_ovf, alu_neg,
    output resp_valid, resp_id, resp_result, resp_flags, resp_err,
    input  resp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  alu_a, alu_b, alu_ctrl,
    output alu_result, alu_zero, alu_carry, alu_ovf, alu_neg,
    input  resp_valid, resp_id, resp_result, resp_flags, resp_err,
    output resp_ready
  );
endinterface

// File: rtl/alu_req_sched.sv
// alu_req_sched
//   Round-robin scheduler that shares one external combinational ALU between
//   two requesters. It grants one request and latches its operands onto the
//   ALU inputs. It holds those inputs for EXEC_CYCLES cycles so the ripple
//   path can settle. It then captures the result and the flags, and returns
//   them on a valid/ready response channel tagged with the requester id.
//
//   Parameters:
//     EXEC_CYCLES - cycles the ALU inputs are held before capture (>= 1)
//     WIDTH       - operand/result width
//   Ports:
//     clk, rst - clock and synchronous active-high reset
//     bus      - alu_req_sched_if.slave (requests, ALU drive, response)
//   Optional (define ALU_REQ_SCHED_STATS_EN):
//     grant_cnt0, grant_cnt1 - saturating accepted-handshake counters
//     err_cnt                - saturating illegal-op capture counter
module alu_req_sched #(
  parameter int unsigned EXEC_CYCLES = 2,
  parameter int unsigned WIDTH       = 64
) (
  input  logic clk,
  input  logic rst,
  alu_req_sched_if.slave bus
`ifdef ALU_REQ_SCHED_STATS_EN
  ,
  output logic [15:0] grant_cnt0,
  output logic [15:0] grant_cnt1,
  output logic [15:0] err_cnt
`endif
);

  localparam int unsigned CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_BEQ = 4'b1010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             rr_ptr;
  logic [CNT_W-1:0] exec_cnt;
  logic             op_id;
  logic             op_illegal;

  logic             grant0;
  logic             grant1;
  logic             ready0;
  logic             ready1;
  logic             hs;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [3:0]       sel_op;
  logic             sel_legal;
  logic             capture;

  function automatic logic op_is_legal(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_BEQ: op_is_legal = 1'b1;
      default:                              op_is_legal = 1'b0;
    endcase
  endfunction

  // Arbitration. When both requesters are valid, rr_ptr breaks the tie.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant0 = ~rr_ptr;
      grant1 = rr_ptr;
    end else begin
      grant0 = bus.req0_valid;
      grant1 = bus.req1_valid;
    end
  end

  // Ready is held low during reset, so a handshake is never offered that the
  // reset would then silently drop.
  always_comb begin
    ready0 = (state == IDLE) && !rst && grant0;
    ready1 = (state == IDLE) && !rst && grant1;
    hs     = ready0 || ready1;
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;

  always_comb begin
    sel_a  = bus.req0_a;
    sel_b  = bus.req0_b;
    sel_op = bus.req0_op;
    if (grant1) begin
      sel_a  = bus.req1_a;
      sel_b  = bus.req1_b;
      sel_op = bus.req1_op;
    end
    sel_legal = op_is_legal(sel_op);
  end

  assign capture = (state == EXEC) && (exec_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      rr_ptr          <= 1'b0;
      exec_cnt        <= '0;
      op_id           <= 1'b0;
      op_illegal      <= 1'b0;
      bus.alu_a       <= '0;
      bus.alu_b       <= '0;
      bus.alu_ctrl    <= '0;
      bus.resp_valid  <= 1'b0;
      bus.resp_id     <= 1'b0;
      bus.resp_result <= '0;
      bus.resp_flags  <= '0;
      bus.resp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            // The ALU inputs are loaded directly here and left alone
            // afterwards, so they stay stable through EXEC and keep their
            // last values in RESP and IDLE.
            bus.alu_a    <= sel_a;
            bus.alu_b    <= sel_b;
            bus.alu_ctrl <= sel_legal ? sel_op : OP_ADD;
            op_illegal   <= !sel_legal;
            op_id        <= grant1;
            rr_ptr       <= ~grant1;
            exec_cnt     <= CNT_LOAD;
            state        <= EXEC;
          end
        end
        EXEC: begin
          if (capture) begin
            bus.resp_valid <= 1'b1;
            bus.resp_id    <= op_id;
            bus.resp_err   <= op_illegal;
            if (op_illegal) begin
              bus.resp_result <= '0;
              bus.resp_flags  <= '0;
            end else begin
              bus.resp_result <= bus.alu_result;
              bus.resp_flags  <= {bus.alu_zero, bus.alu_carry, bus.alu_ovf, bus.alu_neg};
            end
            state <= RESP;
          end else begin
            exec_cnt <= exec_cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_REQ_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
      err_cnt    <= '0;
    end else begin
      if (ready0 && (grant_cnt0 != '1)) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (ready1 && (grant_cnt1 != '1)) grant_cnt1 <= grant_cnt1 + 16'd1;
      if (capture && op_illegal && (err_cnt != '1)) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_req_sched.sv
// tb_alu_req_sched
//   Bench for alu_req_sched. It models the external ALU and runs a
//   transaction-level reference model that predicts grants and responses.
//   A separate monitor checks every response against the queued predictions.
module tb_alu_req_sched;
  localparam int unsigned E = 2;
  localparam int unsigned W = 64;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_BEQ = 4'b1010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;

  alu_req_sched_if #(.WIDTH(W)) bus();

`ifdef ALU_REQ_SCHED_STATS_EN
  logic [15:0] grant_cnt0;
  logic [15:0] grant_cnt1;
  logic [15:0] err_cnt;
  int unsigned m_cnt0 = 0;
  int unsigned m_cnt1 = 0;
  int unsigned m_errc = 0;
`endif

  alu_req_sched #(.EXEC_CYCLES(E), .WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef ALU_REQ_SCHED_STATS_EN
    ,
    .grant_cnt0(grant_cnt0),
    .grant_cnt1(grant_cnt1),
    .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [W-1:0] r;
    logic [3:0]   f;
  } alu_out_t;

  typedef struct {
    bit           id;
    logic [W-1:0] result;
    logic [3:0]   flags;
    bit           err;
    int unsigned  due;
  } exp_t;

  // Behavioural ALU. Flags are {zero, carry, ovf, neg}. SUB and BEQ compute
  // a - b. Carry is the carry out of a + ~b + 1.
  function automatic alu_out_t alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [3:0] op);
    logic [W:0] s;
    logic c, v;
    alu_out_t o;
    s = '0; c = 1'b0; v = 1'b0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        c = s[W];
        v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      end
      OP_SUB, OP_BEQ: begin
        s = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
        c = s[W];
        v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
      end
      OP_AND: s = {1'b0, a & b};
      OP_OR:  s = {1'b0, a | b};
      default: s = '0;
    endcase
    o.r = s[W-1:0];
    o.f = {(o.r == '0), c, v, o.r[W-1]};
    return o;
  endfunction

  function automatic bit is_legal(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR) || (op == OP_BEQ);
  endfunction

  alu_out_t alu_o;
  always_comb begin
    alu_o          = alu_fn(bus.alu_a, bus.alu_b, bus.alu_ctrl);
    bus.alu_result = alu_o.r;
    bus.alu_zero   = alu_o.f[3];
    bus.alu_carry  = alu_o.f[2];
    bus.alu_ovf    = alu_o.f[1];
    bus.alu_neg    = alu_o.f[0];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Reference model state.
  exp_t         sbq[$];
  bit           grant_log[$];
  bit           busy = 1'b0;
  bit           rr = 1'b0;
  int unsigned  due = 0;
  logic [W-1:0] cur_a, cur_b;
  logic [3:0]   cur_ctrl;

  always @(negedge clk) begin
    bit g0, g1, v0, v1, exp_valid;
    exp_t e;
    alu_out_t o;
    if (rst) begin
      chk("ready_in_reset", 64'({bus.req0_ready, bus.req1_ready}), 64'(0));
      busy = 1'b0;
      rr   = 1'b0;
      sbq.delete();
`ifdef ALU_REQ_SCHED_STATS_EN
      m_cnt0 = 0; m_cnt1 = 0; m_errc = 0;
`endif
    end else begin
      v0 = bus.req0_valid;
      v1 = bus.req1_valid;
      g0 = !busy && v0 && (!v1 || !rr);
      g1 = !busy && v1 && (!v0 || rr);
      chk("ready", 64'({bus.req0_ready, bus.req1_ready}), 64'({g0, g1}));
      exp_valid = busy && (cyc >= due);
      chk("resp_valid", 64'(bus.resp_valid), 64'(exp_valid));
      if (busy) begin
        chk("alu_a", bus.alu_a, cur_a);
        chk("alu_b", bus.alu_b, cur_b);
        chk("alu_ctrl", 64'(bus.alu_ctrl), 64'(cur_ctrl));
      end
      if (exp_valid && bus.resp_ready) busy = 1'b0;
      if (g0 || g1) begin
        e.id = g1;
        cur_a = g1 ? bus.req1_a : bus.req0_a;
        cur_b = g1 ? bus.req1_b : bus.req0_b;
        cur_ctrl = g1 ? bus.req1_op : bus.req0_op;
        if (is_legal(cur_ctrl)) begin
          o = alu_fn(cur_a, cur_b, cur_ctrl);
          e.result = o.r; e.flags = o.f; e.err = 1'b0;
        end else begin
          e.result = '0; e.flags = '0; e.err = 1'b1;
          cur_ctrl = OP_ADD;
        end
        e.due = cyc + E + 1;
        sbq.push_back(e);
        grant_log.push_back(g1);
        busy = 1'b1;
        due  = e.due;
        rr   = !g1;
`ifdef ALU_REQ_SCHED_STATS_EN
        if (g1) begin if (m_cnt1 < 65535) m_cnt1++; end
        else    begin if (m_cnt0 < 65535) m_cnt0++; end
        if (e.err && m_errc < 65535) m_errc++;
`endif
      end
    end
  end

  // Response monitor.
  bit           pend = 1'b0;
  logic [W-1:0] h_res;
  logic [3:0]   h_flags;
  logic         h_id, h_err;
  logic [W-1:0] last_result = '0;
  logic [3:0]   last_flags = '0;
  logic         last_id = 1'b0;
  logic         last_err = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      pend = 1'b0;
    end else if (bus.resp_valid) begin
      if (pend) begin
        chk("hold_result", bus.resp_result, h_res);
        chk("hold_id", 64'(bus.resp_id), 64'(h_id));
        chk("hold_flags", 64'(bus.resp_flags), 64'(h_flags));
        chk("hold_err", 64'(bus.resp_err), 64'(h_err));
      end else if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected actual=valid required=no response (cycle %0d)", cyc);
      end else begin
        e = sbq.pop_front();
        chk("resp_id", 64'(bus.resp_id), 64'(e.id));
        chk("resp_result", bus.resp_result, e.result);
        chk("resp_flags", 64'(bus.resp_flags), 64'(e.flags));
        chk("resp_err", 64'(bus.resp_err), 64'(e.err));
        chk("latency", 64'(cyc), 64'(e.due));
        last_result = bus.resp_result;
        last_flags  = bus.resp_flags;
        last_id     = bus.resp_id;
        last_err    = bus.resp_err;
      end
      h_res = bus.resp_result; h_flags = bus.resp_flags;
      h_id  = bus.resp_id;     h_err   = bus.resp_err;
      pend  = !bus.resp_ready;
    end else begin
      pend = 1'b0;
    end
  end

  task automatic issue(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] op);
    bit ok;
    ok = 1'b0;
    if (id) begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_valid = 1'b1;
    end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (id ? bus.req1_ready : bus.req0_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    if (id) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL issue_timeout actual=no ready required=ready for req%0d", id);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 4))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(W-1){1'b0}}};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic logic [3:0] rand_op();
    case ($urandom_range(0, 5))
      0: return OP_ADD;
      1: return OP_SUB;
      2: return OP_AND;
      3: return OP_OR;
      4: return OP_BEQ;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
    bus.resp_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_alu_a", bus.alu_a, 64'(0));
    chk("rst_alu_b", bus.alu_b, 64'(0));
    chk("rst_alu_ctrl", 64'(bus.alu_ctrl), 64'(0));
    chk("rst_resp", 64'({bus.resp_valid, bus.resp_id, bus.resp_flags, bus.resp_err}), 64'(0));
    chk("rst_resp_result", bus.resp_result, 64'(0));

    // Single ADD.
    @(posedge clk); #1;
    issue(1'b0, 64'd5, 64'd7, OP_ADD);
    wait_idle();
    chk("add_result", last_result, 64'd12);
    chk("add_flags", 64'(last_flags), 64'(0));
    chk("add_id", 64'(last_id), 64'(0));

    // Contention: grants must alternate starting with req0.
    do_reset();
    grant_log.delete();
    bus.req0_a = 64'd3; bus.req0_b = 64'd3; bus.req0_op = OP_SUB;
    bus.req1_a = 64'hF0; bus.req1_b = 64'h0F; bus.req1_op = OP_OR;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    repeat (4 * (E + 2) + 1) @(posedge clk);
    #1 bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    wait_idle();
    if (grant_log.size() < 4) begin
      checks++; errors++;
      $display("FAIL grant_count actual=%0d required>=4", grant_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        bit exp_g;
        exp_g = bit'(i % 2);
        chk("grant_order", 64'(grant_log[i]), 64'(exp_g));
      end
    end

    // Backpressure: hold resp_ready low for 5 cycles while both request.
    bus.resp_ready = 1'b0;
    issue(1'b0, 64'd100, 64'd1, OP_SUB);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bus.resp_valid) begin seen = 1'b1; break; end
      end
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL bp_timeout actual=no resp_valid required=resp_valid");
      end
    end
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1 bus.resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    wait_idle();

    // Illegal op, then a normal op.
    issue(1'b1, 64'h1234, 64'h5678, 4'b0111);
    wait_idle();
    chk("illegal_err", 64'(last_err), 64'(1));
    chk("illegal_result", last_result, 64'(0));
    chk("illegal_flags", 64'(last_flags), 64'(0));
    issue(1'b0, 64'd10, 64'd4, OP_SUB);
    wait_idle();
    chk("post_illegal_result", last_result, 64'd6);
    chk("post_illegal_err", 64'(last_err), 64'(0));

    // Reset mid-EXEC, then req0 must win the first contended grant.
    issue(1'b0, 64'd1, 64'd1, OP_ADD);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    grant_log.delete();
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    wait_idle();
    if (grant_log.size() == 0) begin
      checks++; errors++;
      $display("FAIL post_reset_grant actual=none required=req0");
    end else begin
      chk("post_reset_grant", 64'(grant_log[0]), 64'(0));
    end

`ifdef ALU_REQ_SCHED_STATS_EN
    do_reset();
    for (int i = 0; i < 3; i++) issue(1'b0, 64'(i), 64'd2, OP_ADD);
    for (int i = 0; i < 2; i++) issue(1'b1, 64'(i), 64'd2, OP_AND);
    issue(1'b1, 64'd9, 64'd9, 4'b1111);
    wait_idle();
    chk("stat_grant0", 64'(grant_cnt0), 64'd3);
    chk("stat_grant1", 64'(grant_cnt1), 64'd3);
    chk("stat_err", 64'(err_cnt), 64'd1);
`endif

    // Randomized traffic with random backpressure and one reset.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      rst = (i == 700);
      bus.req0_valid = ($urandom_range(0, 2) != 0);
      bus.req0_a = rand_opnd(); bus.req0_b = rand_opnd(); bus.req0_op = rand_op();
      bus.req1_valid = ($urandom_range(0, 2) != 0);
      bus.req1_a = rand_opnd(); bus.req1_b = rand_opnd(); bus.req1_op = rand_op();
      bus.resp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.resp_ready = 1'b1;
    wait_idle();
    repeat (2) @(posedge clk);
    chk("scoreboard_empty", 64'(sbq.size()), 64'(0));
`ifdef ALU_REQ_SCHED_STATS_EN
    chk("stat_grant0_rand", 64'(grant_cnt0), 64'(m_cnt0));
    chk("stat_grant1_rand", 64'(grant_cnt1), 64'(m_cnt1));
    chk("stat_err_rand", 64'(err_cnt), 64'(m_errc));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
